// File: rtl/fsl_pixel_packer_pkg.sv
// Shared types for the pixel packer: word widths, the FIFO word layout and the packer FSM states.
package pixel_pkg;

  localparam int PIX_W = 16;
  localparam int FSL_W = 32;

  typedef struct packed {
    logic             ctrl;
    logic [FSL_W-1:0] data;
  } fsl_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } packer_state_e;

  function automatic fsl_word_t mk_word(input logic ctrl, input logic [FSL_W-1:0] data);
    fsl_word_t w;
    w.ctrl = ctrl;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/fsl_pixel_packer_if.sv
// Pixel-in / FSL-master bundle of the packer; master modport is the packer side.
interface fsl_pixel_packer_if;
  import pixel_pkg::*;

  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eof;
  logic             FSL_M_Write;
  logic [0:FSL_W-1] FSL_M_Data;
  logic             FSL_M_Control;
  logic             FSL_M_Full;
  logic             overflow;
  logic             frame_done;

  modport master (
    input  pix_valid, pix_data, pix_sof, pix_eof, FSL_M_Full,
    output FSL_M_Write, FSL_M_Data, FSL_M_Control, overflow, frame_done
  );

  modport slave (
    output pix_valid, pix_data, pix_sof, pix_eof, FSL_M_Full,
    input  FSL_M_Write, FSL_M_Data, FSL_M_Control, overflow, frame_done
  );

endinterface

// File: rtl/fsl_pixel_packer_fifo.sv
// Show-ahead synchronous FIFO; head is presented combinationally and reads as zero when empty.
module fsl_sync_fifo #(
  parameter int C_WIDTH   = 33,
  parameter int C_FIFO_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [C_WIDTH-1:0]   wr_data,
  input  logic                 rd_en,
  output logic [C_WIDTH-1:0]   rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [C_FIFO_AW:0]   count
);

  localparam int DEPTH = 1 << C_FIFO_AW;
  localparam logic [C_FIFO_AW:0] DEPTH_CNT = {1'b1, {C_FIFO_AW{1'b0}}};

  logic [C_WIDTH-1:0]   mem_q [DEPTH];
  logic [C_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_FIFO_AW:0]   count_q, count_d;
  logic                 wr_ok;
  logic                 rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + C_FIFO_AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + C_FIFO_AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (C_FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (C_FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fsl_pixel_packer.sv
// Packs RGB565 pixel pairs into FSL words, prefixing each frame with a frame-base control word.
// Optional PACKER_KEY_EN replaces the key colour with a fill pixel before packing.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | between frames; pixels without sof are dropped
//   ST_LO   | in frame, waiting for the first pixel of a pair
//   ST_HI   | in frame, first pixel of a pair held in held_q
module fsl_pixel_packer
  import pixel_pkg::*;
#(
  parameter logic [FSL_W-1:0] C_FRAME_BASE = 32'h0000_0000,
  parameter int               C_FIFO_AW    = 4,
  parameter logic [PIX_W-1:0] C_KEY_COLOR  = 16'h07E0,
  parameter logic [PIX_W-1:0] C_KEY_FILL   = 16'h0000
) (
  input logic                 FSL_Clk,
  input logic                 FSL_Rst_n,
  fsl_pixel_packer_if.master  io
);

  packer_state_e    state_q, state_d;
  logic [PIX_W-1:0] held_q, held_d;
  logic             pend_q, pend_d;
  logic [PIX_W-1:0] pend_pix_q, pend_pix_d;
  logic             overflow_q, overflow_d;

  logic [PIX_W-1:0] pix_in;
  logic             push;
  fsl_word_t        push_word;
  logic             last_push;
  logic             ovf_clr;
  logic             ctrl_lost;
  logic             drop;

  fsl_word_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [C_FIFO_AW:0] fifo_count_unused;

`ifdef PACKER_KEY_EN
  assign pix_in = (io.pix_data == C_KEY_COLOR) ? C_KEY_FILL : io.pix_data;
`else
  logic key_unused;
  assign key_unused = ^{C_KEY_COLOR, C_KEY_FILL};
  assign pix_in     = io.pix_data;
`endif

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    pend_d     = pend_q;
    pend_pix_d = pend_pix_q;
    push       = 1'b0;
    push_word  = '0;
    last_push  = 1'b0;
    ovf_clr    = 1'b0;
    ctrl_lost  = 1'b0;

    // Deferred pad word of a single-pixel frame takes this cycle's push slot.
    if (pend_q) begin
      push      = 1'b1;
      push_word = mk_word(1'b0, {pend_pix_q, 16'h0000});
      pend_d    = 1'b0;
      last_push = 1'b1;
    end

    if (io.pix_valid) begin
      if (io.pix_sof) begin
        ovf_clr = 1'b1;
        if (pend_q) begin
          ctrl_lost = 1'b1;
        end else begin
          push      = 1'b1;
          push_word = mk_word(1'b1, C_FRAME_BASE);
        end
        if (io.pix_eof) begin
          pend_d     = 1'b1;
          pend_pix_d = pix_in;
          state_d    = ST_IDLE;
        end else begin
          held_d  = pix_in;
          state_d = ST_HI;
        end
      end else begin
        case (state_q)
          ST_LO: begin
            if (io.pix_eof) begin
              push      = 1'b1;
              push_word = mk_word(1'b0, {pix_in, 16'h0000});
              last_push = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              held_d  = pix_in;
              state_d = ST_HI;
            end
          end
          ST_HI: begin
            push      = 1'b1;
            push_word = mk_word(1'b0, {held_q, pix_in});
            if (io.pix_eof) begin
              last_push = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_LO;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_pop   = !fifo_empty && !io.FSL_M_Full;
  assign drop       = push && fifo_full && !fifo_pop;
  assign overflow_d = (ovf_clr ? 1'b0 : overflow_q) | drop | ctrl_lost;

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      state_q    <= ST_IDLE;
      held_q     <= '0;
      pend_q     <= 1'b0;
      pend_pix_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      pend_pix_q <= pend_pix_d;
      overflow_q <= overflow_d;
    end
  end

  fsl_sync_fifo #(
    .C_WIDTH   ($bits(fsl_word_t)),
    .C_FIFO_AW (C_FIFO_AW)
  ) u_fifo (
    .clk     (FSL_Clk),
    .rst_n   (FSL_Rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign io.FSL_M_Write   = fifo_pop;
  assign io.FSL_M_Data    = head.data;
  assign io.FSL_M_Control = head.ctrl;
  assign io.overflow      = overflow_q;
  assign io.frame_done    = last_push;

endmodule

// File: tb/tb_fsl_pixel_packer.sv
// Scoreboard bench for fsl_pixel_packer: directed frames push expected FSL words, a monitor pops and compares.
module tb_fsl_pixel_packer;
  import pixel_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsl_pixel_packer_if bus();

  fsl_pixel_packer #(
    .C_FRAME_BASE (BASE),
    .C_FIFO_AW    (4),
    .C_KEY_COLOR  (16'h07E0),
    .C_KEY_FILL   (16'h0000)
  ) dut (
    .FSL_Clk   (clk),
    .FSL_Rst_n (rst_n),
    .io        (bus)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  int        fd_cnt   = 0;
  bit        no_write_chk = 1'b0;
  fsl_word_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expw(input logic c, input logic [31:0] d);
    exp_q.push_back(mk_word(c, d));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_done) fd_cnt++;
      if (no_write_chk) check("write_while_full", 64'(bus.FSL_M_Write), 64'd0);
      if (bus.FSL_M_Write) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", {bus.FSL_M_Control, bus.FSL_M_Data});
        end else begin
          fsl_word_t e;
          e = exp_q.pop_front();
          check("fsl_word", 64'({bus.FSL_M_Control, bus.FSL_M_Data}), 64'(e));
        end
      end
    end
  end

  task automatic px(input logic [15:0] d, input logic s, input logic e);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = s;
    bus.pix_eof   = e;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_eof   = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.pix_sof    = 1'b0;
    bus.pix_eof    = 1'b0;
    bus.FSL_M_Full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write",   64'(bus.FSL_M_Write),   64'd0);
    check("rst_data",    64'(bus.FSL_M_Data),    64'd0);
    check("rst_control", 64'(bus.FSL_M_Control), 64'd0);
    check("rst_overflow",64'(bus.overflow),      64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // even frame, two pairs
    fd0 = fd_cnt;
    expw(1'b1, BASE); expw(1'b0, 32'hA1B2_C3D4); expw(1'b0, 32'hA1B2_C3D4);
    px(16'hA1B2, 1'b1, 1'b0); px(16'hC3D4, 1'b0, 1'b0);
    px(16'hA1B2, 1'b0, 1'b0); px(16'hC3D4, 1'b0, 1'b1);
    drain("t1_drain");
    check("t1_frame_done", 64'(fd_cnt - fd0), 64'd1);

    // odd frame, zero-padded last word
    fd0 = fd_cnt;
    expw(1'b1, BASE); expw(1'b0, 32'h1111_2222); expw(1'b0, 32'h3333_0000);
    px(16'h1111, 1'b1, 1'b0); px(16'h2222, 1'b0, 1'b0); px(16'h3333, 1'b0, 1'b1);
    drain("t2_drain");
    check("t2_frame_done", 64'(fd_cnt - fd0), 64'd1);

    // sof mid-frame with a held half-word
    fd0 = fd_cnt;
    expw(1'b1, BASE); expw(1'b0, 32'h5555_6666); expw(1'b1, BASE); expw(1'b0, 32'h8888_9999);
    px(16'h5555, 1'b1, 1'b0); px(16'h6666, 1'b0, 1'b0); px(16'h7777, 1'b0, 1'b0);
    px(16'h8888, 1'b1, 1'b0); px(16'h9999, 1'b0, 1'b1);
    drain("t5_drain");
    check("t5_frame_done", 64'(fd_cnt - fd0), 64'd1);

    // single-pixel frame: control word then deferred pad word
    fd0 = fd_cnt;
    expw(1'b1, BASE); expw(1'b0, 32'hABCD_0000);
    px(16'hABCD, 1'b1, 1'b1);
    drain("tse_drain");
    check("tse_frame_done", 64'(fd_cnt - fd0), 64'd1);

    // key colour
    expw(1'b1, BASE);
`ifdef PACKER_KEY_EN
    expw(1'b0, 32'h0000_1234);
`else
    expw(1'b0, 32'h07E0_1234);
`endif
    px(16'h07E0, 1'b1, 1'b0); px(16'h1234, 1'b0, 1'b1);
    drain("t6_drain");

    // FSL full for the whole burst: 16 words stored, rest dropped
    bus.FSL_M_Full = 1'b1;
    no_write_chk   = 1'b1;
    expw(1'b1, BASE);
    for (int i = 1; i <= 29; i += 2)
      expw(1'b0, {16'(16'h2000 + i), 16'(16'h2000 + i + 1)});
    for (int i = 1; i <= 40; i++)
      px(16'(16'h2000 + i), i == 1, i == 40);
    repeat (5) @(posedge clk);
    #1;
    check("t3_overflow", 64'(bus.overflow), 64'd1);
    check("t3_head", 64'({bus.FSL_M_Control, bus.FSL_M_Data}), 64'({1'b1, BASE}));
    no_write_chk   = 1'b0;
    bus.FSL_M_Full = 1'b0;
    drain("t3_drain");
    check("t3_overflow_sticky", 64'(bus.overflow), 64'd1);

    // full FIFO released the same cycle as a push: no drop
    bus.FSL_M_Full = 1'b1;
    expw(1'b1, BASE);
    for (int i = 1; i <= 31; i += 2)
      expw(1'b0, {16'(16'h3000 + i), 16'(16'h3000 + i + 1)});
    for (int i = 1; i <= 31; i++) begin
      px(16'(16'h3000 + i), i == 1, 1'b0);
      if (i == 1) check("t4_sof_clears_overflow", 64'(bus.overflow), 64'd0);
    end
    bus.FSL_M_Full = 1'b0;
    px(16'h3020, 1'b0, 1'b1);
    check("t4_no_overflow", 64'(bus.overflow), 64'd0);
    drain("t4_drain");
    check("t4_no_overflow_end", 64'(bus.overflow), 64'd0);

    // async reset mid-stream
    bus.FSL_M_Full = 1'b1;
    for (int i = 1; i <= 36; i++)
      px(16'(16'h4000 + i), i == 1, 1'b0);
    check("rs_pre_overflow", 64'(bus.overflow), 64'd1);
    check("rs_pre_head", 64'({bus.FSL_M_Control, bus.FSL_M_Data}), 64'({1'b1, BASE}));
    #2;
    bus.FSL_M_Full = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rs_write",      64'(bus.FSL_M_Write),   64'd0);
    check("rs_data",       64'(bus.FSL_M_Data),    64'd0);
    check("rs_control",    64'(bus.FSL_M_Control), 64'd0);
    check("rs_overflow",   64'(bus.overflow),      64'd0);
    check("rs_frame_done", 64'(bus.frame_done),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    px(16'h1234, 1'b0, 1'b0); px(16'h5678, 1'b0, 1'b1);
    expw(1'b1, BASE); expw(1'b0, 32'hAAAA_BBBB);
    px(16'hAAAA, 1'b1, 1'b0); px(16'hBBBB, 1'b0, 1'b1);
    drain("rs_after_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
